// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} fetch_state_t;
  localparam logic [31:0] NOP_INSTR = 32'hD503201F;
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
  } if_id_t;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register; bubble wins over load, otherwise holds
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = 32'hD503201F
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);
  logic [96:0] r_q;
  assign q = r_q;
  // Register update: reset and bubble both install an empty slot
  always_ff @(posedge clk) begin
    if (!reset_n || bubble) r_q <= {1'b0, BUBBLE_INSTR, 64'd0};
    else if (load) r_q <= d;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, RUN/HALT control and IF/ID capture for the fetch stage
module fetch_stage #(
  parameter int unsigned IMEM_SIZE = 1024,
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [63:0] if_id_pc,
  output logic        halted,
  output logic        fetch_err
);
  import fetch_pkg::*;
  logic [63:0]  r_pc;
  fetch_state_t r_state;
  logic         r_err;
  logic [63:0]  w_pc_nxt;
  fetch_state_t w_state_nxt;
  logic         w_err_set;
  logic         w_load;
  logic         w_bubble;
  logic         w_in_bounds;
  logic         w_tgt_ok;
  if_id_t       w_d;
  if_id_t       w_q;
  assign imem_addr   = r_pc;
  assign w_in_bounds = (r_pc[1:0] == 2'b00) && ((r_pc + 64'd3) < 64'(IMEM_SIZE));
  assign w_tgt_ok    = redirect_target[1:0] == 2'b00;
  assign halted      = r_state == HALT;
  assign fetch_err   = r_err;
  assign w_d         = '{valid: 1'b1, instr: imem_instr, pc: r_pc};
  assign if_id_valid = w_q.valid;
  assign if_id_instr = w_q.instr;
  assign if_id_pc    = w_q.pc;
  // Next PC, next state and IF/ID control; redirect outranks stall, stall outranks the bounds check
  always_comb begin
    w_pc_nxt    = r_pc;
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    if (r_state == HALT) begin
      w_bubble = 1'b1;
      if (redirect_valid && w_tgt_ok) begin
        w_pc_nxt    = redirect_target;
        w_state_nxt = RUN;
      end
      w_err_set = redirect_valid && !w_tgt_ok;
    end else if (redirect_valid) begin
      w_bubble    = 1'b1;
      w_pc_nxt    = w_tgt_ok ? redirect_target : r_pc;
      w_state_nxt = w_tgt_ok ? RUN : HALT;
      w_err_set   = !w_tgt_ok;
    end else if (stall) begin
      w_bubble = flush;
    end else if (!w_in_bounds) begin
      w_state_nxt = HALT;
      w_bubble    = 1'b1;
    end else begin
      w_pc_nxt = r_pc + 64'd4;
      w_load   = 1'b1;
      w_bubble = flush;
    end
  end
  // PC, state and sticky error registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_state <= RUN;
      r_err   <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_state <= w_state_nxt;
      r_err   <= r_err | w_err_set;
    end
  end
  if_id_reg #(.BUBBLE_INSTR(NOP_INSTR)) u_if_id (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (w_load),
    .bubble (w_bubble),
    .d      (w_d),
    .q      (w_q)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'hD503201F;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = 64'd0;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [63:0] if_id_pc;
  logic        halted;
  logic        fetch_err;
  int checks = 0;
  int errors = 0;
  fetch_stage #(.IMEM_SIZE(1024), .RESET_PC(64'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .halted(halted), .fetch_err(fetch_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_word(logic [63:0] a);
    return 32'h1000_0000 | 32'(a[15:0]);
  endfunction
  assign imem_instr = (imem_addr < 64'd1024) ? rom_word(imem_addr) : 32'hDEADBEEF;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset_n = 1'b0;
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 64'h40;
    tick();
    tick();
    checks++;
    if (imem_addr !== 64'd0) begin errors++; $display("FAIL reset_pc got %0h want 0", imem_addr); end
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b0, NOP, 64'd0}) begin
      errors++; $display("FAIL reset_if_id got %0b/%h/%0h want 0/%h/0", if_id_valid, if_id_instr, if_id_pc, NOP);
    end
    checks++;
    if ({halted, fetch_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b want 00", halted, fetch_err); end
    reset_n = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
  endtask
  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_addr !== 64'(4 * i)) begin errors++; $display("FAIL seq_addr%0d got %0h want %0h", i, imem_addr, 4 * i); end
      tick();
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, rom_word(64'(4 * i)), 64'(4 * i)}) begin
        errors++; $display("FAIL seq_if_id%0d got %0b/%h/%0h want 1/%h/%0h", i, if_id_valid, if_id_instr, if_id_pc, rom_word(64'(4 * i)), 4 * i);
      end
    end
  endtask
  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (imem_addr !== 64'd16) begin errors++; $display("FAIL stall_pc%0d got %0h want 10", i, imem_addr); end
      checks++;
      if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, rom_word(64'd12), 64'd12}) begin
        errors++; $display("FAIL stall_hold%0d got %0b/%h/%0h want 1/%h/c", i, if_id_valid, if_id_instr, if_id_pc, rom_word(64'd12));
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({imem_addr, if_id_valid, if_id_instr, if_id_pc} !== {64'd20, 1'b1, rom_word(64'd16), 64'd16}) begin
      errors++; $display("FAIL stall_release got %0h/%0b/%h/%0h want 14/1/%h/10", imem_addr, if_id_valid, if_id_instr, if_id_pc, rom_word(64'd16));
    end
  endtask
  task automatic test_flush();
    flush = 1'b1;
    tick();
    checks++;
    if ({imem_addr, if_id_valid, if_id_instr, if_id_pc} !== {64'd24, 1'b0, NOP, 64'd0}) begin
      errors++; $display("FAIL flush got %0h/%0b/%h/%0h want 18/0/%h/0", imem_addr, if_id_valid, if_id_instr, if_id_pc, NOP);
    end
    stall = 1'b1;
    tick();
    checks++;
    if ({imem_addr, if_id_valid, if_id_instr, if_id_pc} !== {64'd24, 1'b0, NOP, 64'd0}) begin
      errors++; $display("FAIL stall_flush got %0h/%0b/%h/%0h want 18/0/%h/0", imem_addr, if_id_valid, if_id_instr, if_id_pc, NOP);
    end
    flush = 1'b0;
  endtask
  task automatic test_redirect();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 64'h40;
    tick();
    stall = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if ({imem_addr, if_id_valid, if_id_instr, if_id_pc} !== {64'h40, 1'b0, NOP, 64'd0}) begin
      errors++; $display("FAIL redirect got %0h/%0b/%h/%0h want 40/0/%h/0", imem_addr, if_id_valid, if_id_instr, if_id_pc, NOP);
    end
    tick();
    checks++;
    if ({if_id_valid, if_id_instr, if_id_pc} !== {1'b1, rom_word(64'h40), 64'h40}) begin
      errors++; $display("FAIL redirect_fetch got %0b/%h/%0h want 1/%h/40", if_id_valid, if_id_instr, if_id_pc, rom_word(64'h40));
    end
  endtask
  task automatic test_bounds();
    redirect_valid = 1'b1;
    redirect_target = 64'd1016;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({imem_addr, halted, if_id_valid, if_id_instr, if_id_pc} !== {64'd1024, 1'b0, 1'b1, rom_word(64'd1020), 64'd1020}) begin
      errors++; $display("FAIL bounds_last got %0h/%0b/%0b/%h/%0h want 400/0/1/%h/3fc", imem_addr, halted, if_id_valid, if_id_instr, if_id_pc, rom_word(64'd1020));
    end
    tick();
    checks++;
    if ({imem_addr, halted, if_id_valid, if_id_instr, if_id_pc} !== {64'd1024, 1'b1, 1'b0, NOP, 64'd0}) begin
      errors++; $display("FAIL bounds_halt got %0h/%0b/%0b/%h/%0h want 400/1/0/%h/0", imem_addr, halted, if_id_valid, if_id_instr, if_id_pc, NOP);
    end
    stall = 1'b1;
    flush = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    flush = 1'b0;
    checks++;
    if ({imem_addr, halted, if_id_valid, fetch_err} !== {64'd1024, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL halt_frozen got %0h/%0b/%0b/%0b want 400/1/0/0", imem_addr, halted, if_id_valid, fetch_err);
    end
    redirect_valid = 1'b1;
    redirect_target = 64'd0;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_addr, halted, if_id_valid} !== {64'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL halt_exit got %0h/%0b/%0b want 0/0/0", imem_addr, halted, if_id_valid);
    end
    tick();
    checks++;
    if ({imem_addr, if_id_valid, if_id_instr, if_id_pc} !== {64'd4, 1'b1, rom_word(64'd0), 64'd0}) begin
      errors++; $display("FAIL halt_refetch got %0h/%0b/%h/%0h want 4/1/%h/0", imem_addr, if_id_valid, if_id_instr, if_id_pc, rom_word(64'd0));
    end
  endtask
  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_target = 64'h42;
    tick();
    checks++;
    if ({imem_addr, halted, fetch_err, if_id_valid} !== {64'd4, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL misalign got %0h/%0b/%0b/%0b want 4/1/1/0", imem_addr, halted, fetch_err, if_id_valid);
    end
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    checks++;
    if ({imem_addr, halted, fetch_err} !== {64'd4, 1'b1, 1'b1}) begin
      errors++; $display("FAIL misalign_sticky got %0h/%0b/%0b want 4/1/1", imem_addr, halted, fetch_err);
    end
    redirect_valid = 1'b1;
    redirect_target = 64'h80;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if ({imem_addr, halted, fetch_err} !== {64'h80, 1'b0, 1'b1}) begin
      errors++; $display("FAIL err_survives_redirect got %0h/%0b/%0b want 80/0/1", imem_addr, halted, fetch_err);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++;
    if ({imem_addr, halted, fetch_err, if_id_valid} !== {64'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL err_reset got %0h/%0b/%0b/%0b want 0/0/0/0", imem_addr, halted, fetch_err, if_id_valid);
    end
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_flush();
    test_redirect();
    test_bounds();
    test_misaligned();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
